l2_cache_param: RTL

L2_CACHE_PARAM -- requirements
Module: l2_cache_param

---
 rtl/l2_cache_param.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_param.sv
// Write-back, set-associative L2 cache with age-based LRU replacement
// and a flush engine that writes every dirty line back to memory.
module l2_cache_param #(
    parameter int NUM_WAYS  = 8,
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_address,
    input  logic [LINE_BITS-1:0] mem_wdata_l1,
    output logic                 mem_resp,
    output logic [LINE_BITS-1:0] mem_rdata_l1,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);
    localparam int OFF   = $clog2(LINE_BITS / 8);
    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG   = 32 - IDX - OFF;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        IDLE, CHECK, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB
    } state_t;

    state_t state, state_next;

    logic                 valid_arr [NUM_SETS][NUM_WAYS];
    logic                 dirty_arr [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]     age_arr   [NUM_SETS][NUM_WAYS];
    logic [TAG-1:0]       tag_arr   [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0] data_arr  [NUM_SETS][NUM_WAYS];

    logic [WAY_W-1:0] victim_q;
    logic [IDX-1:0]   scan_set;
    logic [WAY_W-1:0] scan_way;
    logic             flush_pend;

    logic [IDX-1:0]   idx;
    logic [TAG-1:0]   tag_in;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;
    logic             scan_last;
    logic             scan_dirty;
    logic             unused_offset;

    // Control strobes from the FSM to the state arrays
    logic                 line_we;
    logic [WAY_W-1:0]     line_way;
    logic [LINE_BITS-1:0] line_data;
    logic                 line_dirty;
    logic                 hit_update;
    logic                 wb_clear;
    logic                 flush_clear;
    logic                 scan_start;
    logic                 scan_adv;
    logic                 victim_load;

    assign idx           = mem_address[OFF+IDX-1:OFF];
    assign tag_in        = mem_address[31:OFF+IDX];
    assign unused_offset = ^mem_address[OFF-1:0];
    assign scan_last     = ({scan_set, scan_way} == '1);
    assign scan_dirty    = valid_arr[scan_set][scan_way] && dirty_arr[scan_set][scan_way];

    // Tag lookup across all ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_arr[idx][w] && (tag_arr[idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest way
    always_comb begin
        victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_arr[idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[idx][w]) victim = WAY_W'(w);
        end
    end

    // FSM next state, outputs and array update strobes
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata_l1 = '0;
        flush_done   = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        line_we      = 1'b0;
        line_way     = victim_q;
        line_data    = mem_wdata_l1;
        line_dirty   = 1'b1;
        hit_update   = 1'b0;
        wb_clear     = 1'b0;
        flush_clear  = 1'b0;
        scan_start   = 1'b0;
        scan_adv     = 1'b0;
        victim_load  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_next = CHECK;
                end else if (flush || flush_pend) begin
                    state_next = FLUSH_SCAN;
                    scan_start = 1'b1;
                end
            end
            CHECK: begin
                if (hit) begin
                    mem_resp   = 1'b1;
                    hit_update = 1'b1;
                    state_next = IDLE;
                    if (mem_write) begin
                        line_we  = 1'b1;
                        line_way = hit_way;
                    end else begin
                        mem_rdata_l1 = data_arr[idx][hit_way];
                    end
                end else begin
                    victim_load = 1'b1;
                    if (valid_arr[idx][victim] && dirty_arr[idx][victim]) begin
                        state_next = WRITEBACK;
                    end else if (mem_write) begin
                        // Clean victim: install directly, the next CHECK hits
                        line_we  = 1'b1;
                        line_way = victim;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[idx][victim_q], idx, {OFF{1'b0}}};
                pmem_wdata   = data_arr[idx][victim_q];
                if (pmem_resp) begin
                    if (mem_write) begin
                        line_we    = 1'b1;
                        state_next = CHECK;
                    end else begin
                        wb_clear   = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:OFF], {OFF{1'b0}}};
                if (pmem_resp) begin
                    line_we    = 1'b1;
                    line_data  = pmem_rdata;
                    line_dirty = 1'b0;
                    state_next = CHECK;
                end
            end
            FLUSH_SCAN: begin
                if (scan_dirty) begin
                    state_next = FLUSH_WB;
                end else if (scan_last) begin
                    flush_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[scan_set][scan_way], scan_set, {OFF{1'b0}}};
                pmem_wdata   = data_arr[scan_set][scan_way];
                if (pmem_resp) begin
                    flush_clear = 1'b1;
                    if (scan_last) begin
                        flush_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        scan_adv   = 1'b1;
                        state_next = FLUSH_SCAN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, valid/dirty/age, flush bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            victim_q   <= '0;
            scan_set   <= '0;
            scan_way   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_arr[s][w] <= 1'b0;
                    dirty_arr[s][w] <= 1'b0;
                    age_arr[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            state <= state_next;
            if (scan_start) begin
                flush_pend <= 1'b0;
            end else if (flush && (state != FLUSH_SCAN) && (state != FLUSH_WB)) begin
                flush_pend <= 1'b1;
            end
            if (victim_load) victim_q <= victim;
            if (scan_start) begin
                {scan_set, scan_way} <= '0;
            end else if (scan_adv) begin
                {scan_set, scan_way} <= {scan_set, scan_way} + 1'b1;
            end
            if (line_we) begin
                valid_arr[idx][line_way] <= 1'b1;
                dirty_arr[idx][line_way] <= line_dirty;
            end
            if (wb_clear)    dirty_arr[idx][victim_q]      <= 1'b0;
            if (flush_clear) dirty_arr[scan_set][scan_way] <= 1'b0;
            if (hit_update) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_arr[idx][w] <= '0;
                    end else if (age_arr[idx][w] < age_arr[idx][hit_way]) begin
                        age_arr[idx][w] <= age_arr[idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Line payload storage (tag and data need no reset; valid gates them)
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_arr[idx][line_way]  <= tag_in;
            data_arr[idx][line_way] <= line_data;
        end
    end

endmodule
